vga_sprite_mover: RTL and testbench

Parametrised multi-sprite overlay stage between the VGA timing generator/image ROM path and the VGA pins. Holds NUM_SPRITES rectangular sprites with per-sprite position registers. Once per frame it moves the selected sprite from the button inputs, with edge clamping and hold-to-accelerate. Per pixel it composites the sprites over the background colour with fixed priority and a registered output.

---
 rtl/vga_sprite_mover.sv | 185 ++++++++++++++++++
 tb/tb_vga_sprite_mover.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_mover.sv
// Multi-sprite overlay stage: per-frame button-driven movement of one selected
// sprite with clamping and hold-to-accelerate, plus per-pixel priority compositing.
module vga_sprite_mover #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 50,
    parameter int SPRITE_H    = 50,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int STEP        = 1,
    parameter int FAST_STEP   = 4,
    parameter int HOLD_FRAMES = 30,
    parameter int COLOR_W     = 12,
    parameter logic [COLOR_W*NUM_SPRITES-1:0] SPRITE_COLORS = 48'hA00_F00_0F0_00F,
    localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_end,
    input  logic                      up,
    input  logic                      down,
    input  logic                      left,
    input  logic                      right,
    input  logic [SEL_W-1:0]          sel,
    input  logic [9:0]                x,
    input  logic [8:0]                y,
    input  logic                      active,
    input  logic [COLOR_W-1:0]        bg_color,
    output logic [COLOR_W-1:0]        pix_color,
    output logic [10*NUM_SPRITES-1:0] pos_x,
    output logic [9*NUM_SPRITES-1:0]  pos_y
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic signed [10:0] X_MAX = 11'(WIDTH - SPRITE_W);
    localparam logic signed [10:0] Y_MAX = 11'(HEIGHT - SPRITE_H);

    if ((NUM_SPRITES < 1) || (NUM_SPRITES > 8) || (NUM_SPRITES * SPRITE_W > WIDTH)) begin : g_param_check
        $error("vga_sprite_mover: unsupported sprite count or sprites do not fit the screen width");
    end

    logic [9:0]          px_q [NUM_SPRITES];
    logic [9:0]          px_d [NUM_SPRITES];
    logic [8:0]          py_q [NUM_SPRITES];
    logic [8:0]          py_d [NUM_SPRITES];
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SEL_W-1:0]    sel_prev_q, sel_prev_d;
    logic                fe_q;
    logic                armed_q;
    logic [COLOR_W-1:0]  pix_q, pix_d;

    logic                tick_s;
    logic                sel_chg_s;
    logic                any_dir_s;
    logic signed [10:0]  step_s;
    logic [9:0]          cur_x_s;
    logic [8:0]          cur_y_s;
    logic signed [10:0]  nx_s, ny_s;
    logic [9:0]          new_x_s;
    logic [8:0]          new_y_s;
    logic                hit_s;
    logic [COLOR_W-1:0]  hit_col_s;

    // armed_q blocks a tick when frame_end is already high as reset releases
    assign tick_s = frame_end & ~fe_q & armed_q;

    // Movement of the selected sprite and hold counter update on the frame tick
    always_comb begin
        px_d       = px_q;
        py_d       = py_q;
        hold_d     = hold_q;
        sel_prev_d = sel_prev_q;
        cur_x_s    = 10'd0;
        cur_y_s    = 9'd0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            cur_x_s = (sel == SEL_W'(i)) ? px_q[i] : cur_x_s;
            cur_y_s = (sel == SEL_W'(i)) ? py_q[i] : cur_y_s;
        end
        sel_chg_s = (sel != sel_prev_q);
        any_dir_s = up | down | left | right;
        step_s    = (!sel_chg_s && (hold_q == HOLD_W'(HOLD_FRAMES))) ? 11'(FAST_STEP) : 11'(STEP);

        if (right && !left) begin
            nx_s = $signed({1'b0, cur_x_s}) + step_s;
        end else if (left && !right) begin
            nx_s = $signed({1'b0, cur_x_s}) - step_s;
        end else begin
            nx_s = $signed({1'b0, cur_x_s});
        end
        if (down && !up) begin
            ny_s = $signed({2'b00, cur_y_s}) + step_s;
        end else if (up && !down) begin
            ny_s = $signed({2'b00, cur_y_s}) - step_s;
        end else begin
            ny_s = $signed({2'b00, cur_y_s});
        end

        if (nx_s < 11'sd0) begin
            new_x_s = 10'd0;
        end else if (nx_s > X_MAX) begin
            new_x_s = X_MAX[9:0];
        end else begin
            new_x_s = nx_s[9:0];
        end
        if (ny_s < 11'sd0) begin
            new_y_s = 9'd0;
        end else if (ny_s > Y_MAX) begin
            new_y_s = Y_MAX[8:0];
        end else begin
            new_y_s = ny_s[8:0];
        end

        if (tick_s) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                px_d[i] = (sel == SEL_W'(i)) ? new_x_s : px_q[i];
                py_d[i] = (sel == SEL_W'(i)) ? new_y_s : py_q[i];
            end
            sel_prev_d = sel;
            if (sel_chg_s || !any_dir_s) begin
                hold_d = {HOLD_W{1'b0}};
            end else if (hold_q == HOLD_W'(HOLD_FRAMES)) begin
                hold_d = hold_q;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else begin
            sel_prev_d = sel_prev_q;
        end
    end

    // Hit test and priority compositing; descending loop lets the lowest index win
    always_comb begin
        hit_s     = 1'b0;
        hit_col_s = {COLOR_W{1'b0}};
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (({1'b0, x} >= {1'b0, px_q[i]}) && ({1'b0, x} < ({1'b0, px_q[i]} + 11'(SPRITE_W))) &&
                ({1'b0, y} >= {1'b0, py_q[i]}) && ({1'b0, y} < ({1'b0, py_q[i]} + 10'(SPRITE_H)))) begin
                hit_s     = 1'b1;
                hit_col_s = SPRITE_COLORS[i*COLOR_W +: COLOR_W];
            end else begin
                hit_col_s = hit_col_s;
            end
        end
        if (!active) begin
            pix_d = {COLOR_W{1'b0}};
        end else if (hit_s) begin
            pix_d = hit_col_s;
        end else begin
            pix_d = bg_color;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_q       <= 1'b0;
            armed_q    <= 1'b0;
            hold_q     <= {HOLD_W{1'b0}};
            sel_prev_q <= {SEL_W{1'b0}};
            pix_q      <= {COLOR_W{1'b0}};
            for (int i = 0; i < NUM_SPRITES; i++) begin
                px_q[i] <= 10'(i * SPRITE_W);
                py_q[i] <= 9'd0;
            end
        end else begin
            fe_q       <= frame_end;
            armed_q    <= armed_q | ~frame_end;
            hold_q     <= hold_d;
            sel_prev_q <= sel_prev_d;
            pix_q      <= pix_d;
            px_q       <= px_d;
            py_q       <= py_d;
        end
    end

    // Flatten position registers onto the output buses
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x[i*10 +: 10] = px_q[i];
            pos_y[i*9 +: 9]   = py_q[i];
        end
    end

    assign pix_color = pix_q;

endmodule

// File: tb/tb_vga_sprite_mover.sv
// Self-checking bench for vga_sprite_mover: constant pixel vectors, directed
// movement corner cases, and randomized frames against a behavioural model.
module tb_vga_sprite_mover;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_end = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [9:0]  x = 10'd0;
    logic [8:0]  y = 9'd0;
    logic        active = 1'b0;
    logic [11:0] bg_color = 12'h000;
    logic [11:0] pix_color;
    logic [39:0] pos_x;
    logic [35:0] pos_y;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int mx [4];
    int my [4];
    int mhold;
    int msel_prev;
    logic [11:0] mcol [4];

    typedef struct {
        logic [9:0]  px;
        logic [8:0]  py;
        logic        act;
        logic [11:0] bg;
        logic [11:0] exp;
    } pix_vec_t;
    pix_vec_t vecs [10];

    vga_sprite_mover dut (
        .clk(clk), .reset(reset), .frame_end(frame_end),
        .up(up), .down(down), .left(left), .right(right), .sel(sel),
        .x(x), .y(y), .active(active), .bg_color(bg_color),
        .pix_color(pix_color), .pos_x(pos_x), .pos_y(pos_y)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = i * 50;
            my[i] = 0;
        end
        mhold = 0;
        msel_prev = 0;
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_tick(input bit u, input bit d, input bit l, input bit r, input int s);
        int st;
        bit any;
        st  = (s == msel_prev && mhold == 30) ? 4 : 1;
        any = u | d | l | r;
        if (r && !l) mx[s] = clampi(mx[s] + st, 590);
        if (l && !r) mx[s] = clampi(mx[s] - st, 590);
        if (d && !u) my[s] = clampi(my[s] + st, 430);
        if (u && !d) my[s] = clampi(my[s] - st, 430);
        if (s != msel_prev || !any) mhold = 0;
        else if (mhold < 30) mhold++;
        msel_prev = s;
    endtask

    function automatic logic [11:0] model_pix(input int px, input int py, input bit a, input logic [11:0] bg);
        if (!a) return 12'h000;
        for (int i = 0; i < 4; i++)
            if (px >= mx[i] && px < mx[i] + 50 && py >= my[i] && py < my[i] + 50) return mcol[i];
        return bg;
    endfunction

    task automatic check_pos(input string name);
        logic [39:0] ex;
        logic [35:0] ey;
        for (int i = 0; i < 4; i++) begin
            ex[i*10 +: 10] = 10'(mx[i]);
            ey[i*9 +: 9]   = 9'(my[i]);
        end
        check({name, "_x"}, 64'(pos_x), 64'(ex));
        check({name, "_y"}, 64'(pos_y), 64'(ey));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_end = 1'b0;
        {up, down, left, right} = 4'b0000;
        sel = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic do_frame(input bit u, input bit d, input bit l, input bit r, input int s, input int len);
        @(negedge clk);
        {up, down, left, right} = {u, d, l, r};
        sel = 2'(s);
        frame_end = 1'b1;
        repeat (len) @(negedge clk);
        frame_end = 1'b0;
        repeat (3) @(negedge clk);
        model_tick(u, d, l, r, s);
        check_pos("frame");
    endtask

    task automatic check_pix(input string name, input int px, input int py, input bit a, input logic [11:0] bg);
        @(negedge clk);
        x = 10'(px);
        y = 9'(py);
        active = a;
        bg_color = bg;
        @(negedge clk);
        check(name, 64'(pix_color), 64'(model_pix(px, py, a, bg)));
    endtask

    // move sprite s right by n pixels at normal speed (n <= 30 per burst)
    task automatic move_right(input int s, input int n);
        int rem;
        rem = n;
        while (rem > 0) begin
            for (int k = 0; k < ((rem > 30) ? 30 : rem); k++) do_frame(0, 0, 0, 1, s, 2);
            rem = rem - ((rem > 30) ? 30 : rem);
            do_frame(0, 0, 0, 0, s, 2);
        end
    endtask

    initial begin
        int lim;
        int s_cur;
        mcol[0] = 12'h00F; mcol[1] = 12'h0F0; mcol[2] = 12'hF00; mcol[3] = 12'hA00;
        vecs[0] = '{10'd55,  9'd10,  1'b1, 12'h123, 12'h0F0};
        vecs[1] = '{10'd0,   9'd0,   1'b1, 12'h123, 12'h00F};
        vecs[2] = '{10'd49,  9'd49,  1'b1, 12'h456, 12'h00F};
        vecs[3] = '{10'd50,  9'd49,  1'b1, 12'h456, 12'h0F0};
        vecs[4] = '{10'd100, 9'd0,   1'b1, 12'h456, 12'hF00};
        vecs[5] = '{10'd199, 9'd49,  1'b1, 12'h789, 12'hA00};
        vecs[6] = '{10'd200, 9'd10,  1'b1, 12'h789, 12'h789};
        vecs[7] = '{10'd10,  9'd50,  1'b1, 12'hABC, 12'hABC};
        vecs[8] = '{10'd55,  9'd10,  1'b0, 12'h123, 12'h000};
        vecs[9] = '{10'd639, 9'd479, 1'b1, 12'hFFF, 12'hFFF};

        // reset state
        repeat (2) @(negedge clk);
        check("reset_pix", 64'(pix_color), 64'h0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_pos_x", 64'(pos_x), 64'h0096_0640_0000 >> 0 & 64'h0 | {24'd0, 10'd150, 10'd100, 10'd50, 10'd0});
        check("reset_pos_y", 64'(pos_y), 64'h0);

        // constant pixel vectors at reset positions
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            x = vecs[i].px; y = vecs[i].py; active = vecs[i].act; bg_color = vecs[i].bg;
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(pix_color), 64'(vecs[i].exp));
        end
        active = 1'b0;

        // right held 3 frames, long frame_end
        for (int k = 0; k < 3; k++) do_frame(0, 0, 0, 1, 0, 8);
        check("right3", 64'(pos_x), {24'd0, 10'd150, 10'd100, 10'd50, 10'd3});

        // left clamp at 0
        do_reset();
        do_frame(0, 0, 1, 0, 0, 2);
        check("left_clamp0", 64'(pos_x[9:0]), 64'd0);

        // right clamp at 590
        lim = 0;
        while (mx[0] < 590 && lim < 300) begin
            do_frame(0, 0, 0, 1, 0, 2);
            lim++;
        end
        check("reach_590", 64'(pos_x[9:0]), 64'd590);
        do_frame(0, 0, 0, 0, 0, 2);
        do_frame(0, 0, 1, 0, 0, 2);
        check("at_589", 64'(pos_x[9:0]), 64'd589);
        do_frame(0, 0, 0, 0, 0, 2);
        do_frame(0, 0, 0, 1, 0, 2);
        check("to_590", 64'(pos_x[9:0]), 64'd590);
        do_frame(0, 0, 0, 1, 0, 2);
        check("stay_590", 64'(pos_x[9:0]), 64'd590);

        // hold to accelerate
        do_reset();
        for (int k = 0; k < 35; k++) do_frame(0, 0, 0, 1, 0, 3);
        check("accel_35", 64'(pos_x[9:0]), 64'd50);
        do_frame(0, 0, 0, 0, 0, 3);
        do_frame(0, 0, 0, 1, 0, 3);
        check("after_release", 64'(pos_x[9:0]), 64'd51);

        // up+down cancels, diagonal-independent move, sel switch drops to STEP
        do_reset();
        do_frame(1, 1, 0, 1, 2, 2);
        check("updown_x", 64'(pos_x[29:20]), 64'd101);
        check("updown_y", 64'(pos_y[26:18]), 64'd0);
        for (int k = 0; k < 31; k++) do_frame(0, 1, 0, 1, 2, 2);
        do_frame(0, 0, 0, 1, 1, 2);
        check("sel_switch", 64'(pos_x[19:10]), 64'd51);

        // overlap priority
        do_reset();
        move_right(0, 100);
        move_right(1, 70);
        check("ovl_pos", 64'(pos_x[19:0]), {44'd0, 10'd120, 10'd100});
        check_pix("ovl_130_10", 130, 10, 1'b1, 12'h321);
        check("ovl_const", 64'(pix_color), 64'h00F);
        check_pix("ovl_149_49", 149, 49, 1'b1, 12'h321);
        check_pix("ovl_150_49", 150, 49, 1'b1, 12'h321);
        check_pix("ovl_170_49", 170, 49, 1'b1, 12'h321);
        check_pix("ovl_170_50", 170, 50, 1'b1, 12'h321);
        check_pix("ovl_inactive", 130, 10, 1'b0, 12'h321);
        check("inactive_const", 64'(pix_color), 64'h0);

        // reset mid-frame with frame_end held across release
        do_reset();
        do_frame(0, 0, 0, 1, 0, 2);
        @(negedge clk);
        right = 1'b1;
        frame_end = 1'b1;
        @(negedge clk);
        model_tick(0, 0, 0, 1, 0);
        reset = 1'b1;
        #1;
        model_reset();
        check_pos("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        frame_end = 1'b0;
        repeat (2) @(negedge clk);
        check_pos("no_tick_at_release");
        do_frame(0, 0, 0, 1, 0, 2);
        check("first_tick_after_reset", 64'(pos_x[9:0]), 64'd1);

        // randomized frames and pixels against the model
        do_reset();
        s_cur = 0;
        for (int k = 0; k < 120; k++) begin
            logic [3:0] dirs;
            int t;
            dirs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) s_cur = $urandom_range(0, 3);
            do_frame(dirs[3], dirs[2], dirs[1], dirs[0], s_cur, $urandom_range(1, 8));
            for (int p = 0; p < 2; p++) begin
                t = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1)
                    check_pix("rand_pix", clampi(mx[t] + $urandom_range(0, 53) - 2, 639),
                              clampi(my[t] + $urandom_range(0, 53) - 2, 479),
                              $urandom_range(0, 3) != 0, 12'($urandom));
                else
                    check_pix("rand_pix", $urandom_range(0, 639), $urandom_range(0, 479),
                              $urandom_range(0, 3) != 0, 12'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
